// File: rtl/syn_fifo.sv
// rtl/syn_fifo.sv - single-clock parametrised FIFO with fill count, thresholds, FWFT, flush and sticky errors
//
// Ports:
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   flush             : synchronous empty request (pointers/count to 0)
//   wdata, winc       : write data and write request
//   wfull, almost_full: occupancy == DEPTH, occupancy >= AFULL_TH
//   rinc, rdata       : read request (pop in FWFT mode) and read data
//   rempty, almost_empty: occupancy == 0, occupancy <= AEMPTY_TH
//   count             : registered occupancy 0..DEPTH
//   overflow, underflow, err_clr : sticky rejected-write/read flags and their clear

module syn_fifo #(
    parameter int WIDTH     = 8,
    parameter int ADDRSIZE  = 4,
    parameter int AFULL_TH  = (2 ** ADDRSIZE) - 2,
    parameter int AEMPTY_TH = 1,
    parameter int FWFT      = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic [WIDTH-1:0]    wdata,
    input  logic                winc,
    output logic                wfull,
    output logic                almost_full,
    input  logic                rinc,
    output logic [WIDTH-1:0]    rdata,
    output logic                rempty,
    output logic                almost_empty,
    output logic [ADDRSIZE:0]   count,
    output logic                overflow,
    output logic                underflow,
    input  logic                err_clr
);

    localparam int DEPTH = 2 ** ADDRSIZE;
    localparam logic [ADDRSIZE:0] C_DEPTH  = (ADDRSIZE+1)'(DEPTH);
    localparam logic [ADDRSIZE:0] C_AFULL  = (ADDRSIZE+1)'(AFULL_TH);
    localparam logic [ADDRSIZE:0] C_AEMPTY = (ADDRSIZE+1)'(AEMPTY_TH);
    localparam logic [ADDRSIZE:0] C_ONE    = (ADDRSIZE+1)'(1);

    logic [WIDTH-1:0]  r_mem [0:DEPTH-1];
    logic [ADDRSIZE:0] r_wptr;
    logic [ADDRSIZE:0] r_rptr;
    logic [ADDRSIZE:0] r_count;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_wr_en;
    logic              w_rd_en;
    logic [ADDRSIZE-1:0] w_waddr;
    logic [ADDRSIZE-1:0] w_raddr;
    logic              w_unused_ptr_msb;

    assign wfull        = (r_count == C_DEPTH);
    assign rempty       = (r_count == '0);
    assign almost_full  = (r_count >= C_AFULL);
    assign almost_empty = (r_count <= C_AEMPTY);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    // Flush (and reset) suppress both requests so nothing moves in that cycle.
    assign w_wr_en = winc & ~wfull  & ~flush & ~rst;
    assign w_rd_en = rinc & ~rempty & ~flush & ~rst;

    assign w_waddr = r_wptr[ADDRSIZE-1:0];
    assign w_raddr = r_rptr[ADDRSIZE-1:0];
    // Pointer MSBs are kept as lap bits only; occupancy comes from r_count.
    assign w_unused_ptr_msb = r_wptr[ADDRSIZE] ^ r_rptr[ADDRSIZE];

    // Storage array is intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            if (err_clr) begin
                r_overflow  <= 1'b0;
                r_underflow <= 1'b0;
            end
        end else begin
            if (w_wr_en) begin
                r_wptr <= r_wptr + C_ONE;
            end
            if (w_rd_en) begin
                r_rptr <= r_rptr + C_ONE;
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + C_ONE;
                2'b01:   r_count <= r_count - C_ONE;
                default: r_count <= r_count;
            endcase
            // A new error in the same cycle as err_clr keeps the flag set.
            r_overflow  <= (winc & wfull)  | (r_overflow  & ~err_clr);
            r_underflow <= (rinc & rempty) | (r_underflow & ~err_clr);
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign rdata = r_mem[w_raddr];
        end else begin : g_std
            logic [WIDTH-1:0] r_rdata;
            // Flush leaves the output register alone; only reset clears it.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rdata <= '0;
                end else if (w_rd_en) begin
                    r_rdata <= r_mem[w_raddr];
                end
            end
            assign rdata = r_rdata;
        end
    endgenerate

endmodule

// File: tb/tb_syn_fifo.sv
// tb/tb_syn_fifo.sv - directed scoreboard bench for syn_fifo in standard and FWFT modes

module tb_syn_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;

    logic       s_flush, s_winc, s_rinc, s_err_clr;
    logic [7:0] s_wdata, s_rdata;
    logic       s_wfull, s_af, s_rempty, s_ae, s_ovf, s_unf;
    logic [3:0] s_count;

    logic       f_flush, f_winc, f_rinc, f_err_clr;
    logic [7:0] f_wdata, f_rdata;
    logic       f_wfull, f_af, f_rempty, f_ae, f_ovf, f_unf;
    logic [3:0] f_count;

    syn_fifo #(.WIDTH(8), .ADDRSIZE(3), .AFULL_TH(6), .AEMPTY_TH(1), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .flush(s_flush), .wdata(s_wdata), .winc(s_winc),
        .wfull(s_wfull), .almost_full(s_af), .rinc(s_rinc), .rdata(s_rdata),
        .rempty(s_rempty), .almost_empty(s_ae), .count(s_count),
        .overflow(s_ovf), .underflow(s_unf), .err_clr(s_err_clr)
    );

    syn_fifo #(.WIDTH(8), .ADDRSIZE(3), .AFULL_TH(6), .AEMPTY_TH(1), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .flush(f_flush), .wdata(f_wdata), .winc(f_winc),
        .wfull(f_wfull), .almost_full(f_af), .rinc(f_rinc), .rdata(f_rdata),
        .rempty(f_rempty), .almost_empty(f_ae), .count(f_count),
        .overflow(f_ovf), .underflow(f_unf), .err_clr(f_err_clr)
    );

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] sq[$];
    logic [7:0] fq[$];
    logic [7:0] exp_d;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        s_flush = 0; s_winc = 1; s_rinc = 1; s_err_clr = 0; s_wdata = 8'hEE;
        f_flush = 0; f_winc = 1; f_rinc = 1; f_err_clr = 0; f_wdata = 8'hEE;
        tick();
        tick();
        rst = 1'b0;
        s_winc = 0; s_rinc = 0;
        f_winc = 0; f_rinc = 0;

        check("rst_count",  s_count, 0);
        check("rst_rempty", s_rempty, 1);
        check("rst_wfull",  s_wfull, 0);
        check("rst_ae",     s_ae, 1);
        check("rst_af",     s_af, 0);
        check("rst_ovf",    s_ovf, 0);
        check("rst_unf",    s_unf, 0);
        check("rst_rdata",  s_rdata, 0);
        check("rst_f_count", f_count, 0);
        check("rst_f_rempty", f_rempty, 1);

        // Fill 0x10..0x17
        for (int i = 0; i < 8; i++) begin
            s_wdata = 8'h10 + 8'(i);
            s_winc  = 1;
            sq.push_back(s_wdata);
            tick();
            check("fill_count", s_count, i + 1);
            check("fill_af", s_af, (i + 1 >= 6) ? 1 : 0);
            check("fill_wfull", s_wfull, (i == 7) ? 1 : 0);
        end
        s_winc = 0;

        // Full collision: read accepted, write rejected
        s_winc = 1; s_rinc = 1; s_wdata = 8'h99;
        exp_d = sq.pop_front();
        tick();
        s_winc = 0; s_rinc = 0;
        check("full_col_count", s_count, 7);
        check("full_col_ovf", s_ovf, 1);
        check("full_col_rdata", s_rdata, exp_d);
        check("full_col_wfull", s_wfull, 0);

        // Drain remaining 7
        for (int i = 0; i < 7; i++) begin
            s_rinc = 1;
            exp_d = sq.pop_front();
            tick();
            check("drain_rdata", s_rdata, exp_d);
        end
        s_rinc = 0;
        check("drain_rempty", s_rempty, 1);
        check("drain_count", s_count, 0);
        tick();
        check("drain_hold", s_rdata, 8'h17);

        // Empty collision: write accepted, read rejected
        s_winc = 1; s_rinc = 1; s_wdata = 8'hAA;
        sq.push_back(8'hAA);
        tick();
        s_winc = 0; s_rinc = 0;
        check("empty_col_count", s_count, 1);
        check("empty_col_unf", s_unf, 1);
        check("empty_col_ovf", s_ovf, 1);
        check("empty_col_rdata", s_rdata, 8'h17);

        s_err_clr = 1;
        tick();
        s_err_clr = 0;
        check("errclr_ovf", s_ovf, 0);
        check("errclr_unf", s_unf, 0);

        // Bring count to 3, then wrap with simultaneous write/read
        for (int i = 0; i < 2; i++) begin
            s_wdata = 8'h20 + 8'(i);
            s_winc = 1;
            sq.push_back(s_wdata);
            tick();
        end
        s_winc = 0;
        check("wrap_pre_count", s_count, 3);
        for (int i = 0; i < 20; i++) begin
            s_wdata = 8'h30 + 8'(i);
            s_winc = 1; s_rinc = 1;
            sq.push_back(s_wdata);
            exp_d = sq.pop_front();
            tick();
            check("wrap_rdata", s_rdata, exp_d);
            check("wrap_count", s_count, 3);
        end
        s_winc = 0; s_rinc = 0;
        for (int i = 0; i < 3; i++) begin
            s_rinc = 1;
            exp_d = sq.pop_front();
            tick();
            check("wrap_drain", s_rdata, exp_d);
        end
        s_rinc = 0;
        check("wrap_rempty", s_rempty, 1);

        // Flush mid-burst at count 5 with winc high
        for (int i = 0; i < 5; i++) begin
            s_wdata = 8'h40 + 8'(i);
            s_winc = 1;
            tick();
        end
        check("pre_flush_count", s_count, 5);
        s_flush = 1; s_wdata = 8'h77;
        tick();
        s_flush = 0; s_winc = 0;
        sq.delete();
        check("flush_count", s_count, 0);
        check("flush_rempty", s_rempty, 1);
        check("flush_ovf", s_ovf, 0);
        check("flush_rdata_kept", s_rdata, 8'h22 + 8'h30 - 8'h22 + 8'h13);
        s_wdata = 8'h33; s_winc = 1;
        sq.push_back(8'h33);
        tick();
        s_winc = 0;
        s_rinc = 1;
        exp_d = sq.pop_front();
        tick();
        s_rinc = 0;
        check("post_flush_rdata", s_rdata, exp_d);
        check("post_flush_rempty", s_rempty, 1);

        // FWFT mode
        f_wdata = 8'h5A; f_winc = 1;
        fq.push_back(8'h5A);
        tick();
        f_winc = 0;
        check("fwft_rempty", f_rempty, 0);
        check("fwft_rdata", f_rdata, fq[0]);
        tick();
        check("fwft_rdata_hold", f_rdata, fq[0]);
        f_rinc = 1;
        void'(fq.pop_front());
        tick();
        f_rinc = 0;
        check("fwft_pop_rempty", f_rempty, 1);

        for (int i = 0; i < 2; i++) begin
            f_wdata = 8'h61 + 8'(i);
            f_winc = 1;
            fq.push_back(f_wdata);
            tick();
        end
        f_winc = 0;
        check("fwft_head0", f_rdata, fq[0]);
        f_rinc = 1;
        void'(fq.pop_front());
        tick();
        f_rinc = 0;
        check("fwft_head1", f_rdata, fq[0]);
        check("fwft_count1", f_count, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/syn_fifo.md
# syn_fifo

Single-clock, parametrised FIFO; the synchronous counterpart of the dual-clock FIFO, for paths where producer and consumer share one clock. It adds the following over the dual-clock block:
- fill count and programmable almost-full/almost-empty thresholds;
- selectable first-word-fall-through (FWFT) read mode;
- synchronous flush;
- sticky overflow/underflow error flags.

## Interface
- WIDTH, 8: data word width in bits.
- ADDRSIZE, 4: address width; DEPTH = 2**ADDRSIZE entries.
- AFULL_TH, DEPTH-2: almost_full asserts when count >= AFULL_TH; legal range 1..DEPTH.
- AEMPTY_TH, 1: almost_empty asserts when count <= AEMPTY_TH; legal range 0..DEPTH-1.
- FWFT, 0: 0 = registered read (standard); 1 = first-word-fall-through.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- flush  input  1  synchronous empty request.
- wdata  input  WIDTH  write data.
- winc  input  1  write request.
- wfull  output  1  FIFO holds DEPTH words.
- almost_full  output  1  count >= AFULL_TH.
- rinc  input  1  read request.
- rdata  output  WIDTH  read data.
- rempty  output  1  FIFO holds 0 words.
- almost_empty  output  1  count <= AEMPTY_TH.
- count  output  ADDRSIZE+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: a write was rejected while full.
- underflow  output  1  sticky: a read was rejected while empty.
- err_clr  input  1  clears overflow and underflow.

## Operation
- Storage: DEPTH x WIDTH register array. Write and read pointers are ADDRSIZE+1 bits; the low ADDRSIZE bits address the array and wrap DEPTH-1 -> 0.
- count is a registered up/down counter; it is never derived from a pointer difference at the output.
- Accept rules:
  - wr_en = winc & !wfull.
  - rd_en = rinc & !rempty.
  - Both are evaluated on the current registered flags.
- Simultaneous accepted write and read: both pointers advance and count is unchanged.
- When full with winc and rinc both high: the read is accepted, the write is rejected, and overflow sets. Next cycle count = DEPTH-1.
- When empty with winc and rinc both high: the write is accepted, the read is rejected, and underflow sets. Next cycle count = 1.
- Flags are combinational from registered count:
  - wfull = (count == DEPTH).
  - rempty = (count == 0).
  - almost_full and almost_empty per the threshold definitions.
- overflow / underflow:
  - set on winc&wfull / rinc&rempty respectively;
  - held until err_clr or rst;
  - a set in the same cycle as err_clr wins (the flag stays 1).
- Standard mode (FWFT=0): rdata is a register, loaded from array[raddr] on rd_en and otherwise held.
- FWFT mode (FWFT=1):
  - rdata = array[raddr] combinationally, valid whenever rempty=0;
  - rinc acts as pop/acknowledge;
  - when rempty=1, rdata is don't-care.
- flush:
  - next cycle pointers = 0, count = 0, rempty = 1;
  - array contents and rdata register are untouched;
  - winc/rinc in the flush cycle are ignored and set no error flags.
- Priority: rst > flush > normal operation.

## Timing
- Reset values:
  - count 0, rempty 1, wfull 0;
  - almost_empty 1, almost_full 0;
  - overflow 0, underflow 0;
  - rdata 0 (standard mode);
  - pointers 0.
  - Array contents are not reset.
- Write latency: a word written at edge N is counted at N+1.
  - At N+1, rempty deasserts if the FIFO was empty.
  - In FWFT mode the word is visible on rdata at N+1.
  - It can be read by rinc sampled at edge N+1.
- Standard-mode read latency: rinc accepted at edge N gives rdata valid after edge N (one cycle), held until the next accepted read.
- FWFT read: rinc accepted at edge N gives the next word (or rempty=1) after edge N.
- Full-flag latency: the DEPTH-th write at edge N gives wfull=1 after N; a read at N+1 gives wfull=0 after N+1.
- Back-to-back full-rate writes and reads are sustained indefinitely at one word per cycle each.
- rst or flush asserted mid-burst takes effect at that edge; the next cycle behaves as a fresh empty FIFO.

## Test plan
Bench configuration: WIDTH=8, ADDRSIZE=3 (DEPTH 8), AFULL_TH=6, AEMPTY_TH=1.

- Reset:
  - assert rst 2 cycles with winc=rinc=1 -> count=0, rempty=1, wfull=0, almost_empty=1, no error flags set.
- Fill/drain, FWFT=0:
  - write 0x10..0x17 -> almost_full=1 after the 6th write, wfull=1 after the 8th, count=8;
  - read 8 -> rdata 0x10..0x17 in order, each one cycle after its rinc, rempty=1 after the last.
- Boundary collisions:
  - when full, winc=rinc=1 -> count 7, overflow=1, read data 0x10;
  - when empty, winc=rinc=1 with wdata 0xAA -> count 1, underflow=1;
  - err_clr -> both flags 0.
- Wrap-around:
  - 20 cycles of simultaneous write/read at count=3 with an incrementing pattern -> count stays 3 and output order is preserved across pointer wrap.
- FWFT=1:
  - write 0x5A into empty -> rempty=0 and rdata=0x5A one cycle later with no rinc;
  - rinc -> rempty=1 next cycle.
- Flush mid-burst:
  - with count=5, assert flush with winc=1 -> count=0, rempty=1, no overflow;
  - the next write of 0x33 is the first word read back.
